// File: rtl/frame_unpacker_80m_pkg.sv
// Shared link package for the coax frame packer/unpacker.
// Holds the default sync/CRC constants, the frame field positions,
// the serial CRC-8 next-bit function and the deframer state enum.
package frame_unpacker_80m_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] CRC_POLY_DEF  = 8'h07;
  localparam logic [7:0] CRC_INIT_DEF  = 8'h00;

  // Frame field boundaries (bit indices, MSB first on the wire)
  localparam int FRAME_W      = 56;  // total frame length
  localparam int SYNC_LSB     = 48;  // [55:48] sync
  localparam int CNT_LSB      = 40;  // [47:40] counter
  localparam int DATA_LSB     = 8;   // [39:8] data, [7:0] CRC
  localparam int PAYLOAD_BITS = SYNC_LSB - DATA_LSB;  // CRC-covered bits
  localparam int CRC_BITS     = DATA_LSB;
  localparam int SYNC_BITS    = FRAME_W - SYNC_LSB;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CRC     = 2'd2
  } link_state_e;

  // One MSB-first CRC-8 step: no reflection, no final XOR.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc,
                                           input logic       b,
                                           input logic [7:0] poly);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/frame_unpacker_80m_crc8_serial.sv
// crc8_serial: bit-serial CRC-8 register.
// Ports: clk, rst_n (async active-low), init (load CRC_INIT, wins over en),
//        en (advance one bit), bit_in (data bit), crc_out (current CRC).
module crc8_serial
  import frame_unpacker_80m_pkg::*;
#(
  parameter logic [7:0] CRC_POLY = CRC_POLY_DEF,
  parameter logic [7:0] CRC_INIT = CRC_INIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc_out
);

  logic [7:0] crc_d, crc_q;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = crc8_next(crc_q, bit_in, CRC_POLY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/frame_unpacker_80m.sv
// frame_unpacker_80m: receive deframer for the single-wire coax link.
// Hunts for the sync byte in the recovered bit stream, collects the
// 40-bit counter+data payload, checks the trailing CRC-8 and presents the
// data word and frame counter on a valid/ready output with error statistics.
// Ports:
//   clk, rst_n            80 MHz link clock, async active-low reset
//   bit_in, bit_valid     recovered bit stream, MSB first, no backpressure
//   out_data, out_count   received word and frame counter
//   out_valid, out_ready  output handshake
//   locked                last completed frame passed CRC
//   crc_err_cnt, seq_err_cnt, ovf_cnt  saturating statistics
module frame_unpacker_80m
  import frame_unpacker_80m_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter logic [7:0] CRC_POLY  = CRC_POLY_DEF,
  parameter logic [7:0] CRC_INIT  = CRC_INIT_DEF,
  parameter int         CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic [31:0]          out_data,
  output logic [7:0]           out_count,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 locked,
  output logic [CNT_WIDTH-1:0] crc_err_cnt,
  output logic [CNT_WIDTH-1:0] seq_err_cnt,
  output logic [CNT_WIDTH-1:0] ovf_cnt
);

  localparam logic [5:0] PAYLOAD_LAST = 6'(PAYLOAD_BITS - 1);
  localparam logic [5:0] CRC_LAST     = 6'(CRC_BITS - 1);
  localparam logic [3:0] FILL_FULL    = 4'(SYNC_BITS);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  link_state_e                 state_d, state_q;
  logic [7:0]                  sh8_d, sh8_q;
  logic [3:0]                  fill_d, fill_q;
  logic [5:0]                  bitcnt_d, bitcnt_q;
  logic [PAYLOAD_BITS-1:0]     pay_d, pay_q;
  logic [31:0]                 out_data_d, out_data_q;
  logic [7:0]                  out_count_d, out_count_q;
  logic                        out_valid_d, out_valid_q;
  logic                        locked_d, locked_q;
  logic [7:0]                  last_count_d, last_count_q;
  logic                        have_prev_d, have_prev_q;
  logic [CNT_WIDTH-1:0]        crc_err_d, crc_err_q;
  logic [CNT_WIDTH-1:0]        seq_err_d, seq_err_q;
  logic [CNT_WIDTH-1:0]        ovf_d, ovf_q;

  logic       crc_init, crc_en, frame_done;
  logic [7:0] crc_calc, rx_crc, rx_count;
  logic [31:0] rx_data;

  crc8_serial #(
    .CRC_POLY (CRC_POLY),
    .CRC_INIT (CRC_INIT)
  ) u_crc (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (crc_init),
    .en      (crc_en),
    .bit_in  (bit_in),
    .crc_out (crc_calc)
  );

  // The received CRC byte shares the sync shift register; fill is cleared
  // on the way back to HUNT so the stale contents are never matched.
  assign rx_crc   = {sh8_q[6:0], bit_in};
  assign rx_count = pay_q[CNT_LSB-DATA_LSB +: 8];
  assign rx_data  = pay_q[31:0];

  // Deframer FSM: everything freezes while bit_valid is low
  always_comb begin
    state_d    = state_q;
    sh8_d      = sh8_q;
    fill_d     = fill_q;
    bitcnt_d   = bitcnt_q;
    pay_d      = pay_q;
    crc_init   = 1'b0;
    crc_en     = 1'b0;
    frame_done = 1'b0;
    if (bit_valid) begin
      case (state_q)
        ST_HUNT: begin
          sh8_d  = {sh8_q[6:0], bit_in};
          fill_d = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 4'd1;
          if (fill_d == FILL_FULL && sh8_d == SYNC_BYTE) begin
            state_d  = ST_PAYLOAD;
            bitcnt_d = '0;
            crc_init = 1'b1;
          end
        end
        ST_PAYLOAD: begin
          pay_d    = {pay_q[PAYLOAD_BITS-2:0], bit_in};
          crc_en   = 1'b1;
          bitcnt_d = bitcnt_q + 6'd1;
          if (bitcnt_q == PAYLOAD_LAST) begin
            state_d  = ST_CRC;
            bitcnt_d = '0;
          end
        end
        ST_CRC: begin
          sh8_d    = {sh8_q[6:0], bit_in};
          bitcnt_d = bitcnt_q + 6'd1;
          if (bitcnt_q == CRC_LAST) begin
            frame_done = 1'b1;
            state_d    = ST_HUNT;
            fill_d     = '0;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // Frame verdict, output register and statistics
  always_comb begin
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;
    out_valid_d  = out_valid_q && !out_ready;
    locked_d     = locked_q;
    last_count_d = last_count_q;
    have_prev_d  = have_prev_q;
    crc_err_d    = crc_err_q;
    seq_err_d    = seq_err_q;
    ovf_d        = ovf_q;
    if (frame_done) begin
      if (rx_crc == crc_calc) begin
        locked_d = 1'b1;
        if (have_prev_q && rx_count != last_count_q + 8'd1) begin
          seq_err_d = sat_inc(seq_err_q);
        end
        last_count_d = rx_count;
        have_prev_d  = 1'b1;
        // A word being accepted this cycle frees the register for the new one
        if (!out_valid_q || out_ready) begin
          out_data_d  = rx_data;
          out_count_d = rx_count;
          out_valid_d = 1'b1;
        end else begin
          ovf_d = sat_inc(ovf_q);
        end
      end else begin
        locked_d  = 1'b0;
        crc_err_d = sat_inc(crc_err_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HUNT;
      sh8_q        <= '0;
      fill_q       <= '0;
      bitcnt_q     <= '0;
      pay_q        <= '0;
      out_data_q   <= '0;
      out_count_q  <= '0;
      out_valid_q  <= 1'b0;
      locked_q     <= 1'b0;
      last_count_q <= '0;
      have_prev_q  <= 1'b0;
      crc_err_q    <= '0;
      seq_err_q    <= '0;
      ovf_q        <= '0;
    end else begin
      state_q      <= state_d;
      sh8_q        <= sh8_d;
      fill_q       <= fill_d;
      bitcnt_q     <= bitcnt_d;
      pay_q        <= pay_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
      out_valid_q  <= out_valid_d;
      locked_q     <= locked_d;
      last_count_q <= last_count_d;
      have_prev_q  <= have_prev_d;
      crc_err_q    <= crc_err_d;
      seq_err_q    <= seq_err_d;
      ovf_q        <= ovf_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_count   = out_count_q;
  assign out_valid   = out_valid_q;
  assign locked      = locked_q;
  assign crc_err_cnt = crc_err_q;
  assign seq_err_cnt = seq_err_q;
  assign ovf_cnt     = ovf_q;

endmodule

// File: tb/tb_frame_unpacker_80m.sv
// Testbench for frame_unpacker_80m: frame-level reference model plus
// directed scenarios and a randomized frame stream.
module tb_frame_unpacker_80m;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [7:0]  out_count;
  logic        out_valid;
  logic        locked;
  logic [15:0] crc_err_cnt, seq_err_cnt, ovf_cnt;

  frame_unpacker_80m dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .out_data    (out_data),
    .out_count   (out_count),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .locked      (locked),
    .crc_err_cnt (crc_err_cnt),
    .seq_err_cnt (seq_err_cnt),
    .ovf_cnt     (ovf_cnt)
  );

  always #6 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;
  bit rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] crc8_ref(input logic [39:0] v);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = c[7] ^ v[i];
      c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic logic [55:0] make_frame(input logic [7:0] cnt, input logic [31:0] data);
    logic [39:0] p;
    p = {cnt, data};
    return {8'hA5, p, crc8_ref(p)};
  endfunction

  // ---------------- reference model (frame level) ----------------
  bit          m_in_frame = 0;
  int          m_since_hunt = 0;
  logic [7:0]  m_win = 0;
  logic [47:0] m_buf = 0;
  int          m_nb = 0;
  logic        m_valid = 0, m_locked = 0, m_have_prev = 0;
  logic [7:0]  m_count = 0, m_last = 0;
  logic [31:0] m_data = 0;
  int unsigned m_crc_err = 0, m_seq_err = 0, m_ovf = 0;
  int          m_acc = 0;

  always @(posedge clk or negedge rst_n) begin
    bit done, loaded, hs;
    if (!rst_n) begin
      m_in_frame = 0; m_since_hunt = 0; m_win = 0; m_buf = 0; m_nb = 0;
      m_valid = 0; m_locked = 0; m_have_prev = 0; m_count = 0; m_last = 0;
      m_data = 0; m_crc_err = 0; m_seq_err = 0; m_ovf = 0; m_acc = 0;
    end else begin
      done = 0; loaded = 0;
      hs = m_valid && out_ready;
      if (bit_valid) begin
        if (!m_in_frame) begin
          m_win = {m_win[6:0], bit_in};
          m_since_hunt++;
          if (m_since_hunt >= 8 && m_win == 8'hA5) begin
            m_in_frame = 1; m_nb = 0;
          end
        end else begin
          m_buf = {m_buf[46:0], bit_in};
          m_nb++;
          if (m_nb == 48) begin
            done = 1; m_in_frame = 0; m_since_hunt = 0;
          end
        end
      end
      if (hs) m_acc++;
      if (done) begin
        if (crc8_ref(m_buf[47:8]) == m_buf[7:0]) begin
          m_locked = 1;
          if (m_have_prev && m_buf[47:40] != 8'(m_last + 8'd1))
            if (m_seq_err < 65535) m_seq_err++;
          m_last = m_buf[47:40];
          m_have_prev = 1;
          if (!m_valid || out_ready) begin
            m_count = m_buf[47:40]; m_data = m_buf[39:8]; m_valid = 1; loaded = 1;
          end else if (m_ovf < 65535) m_ovf++;
        end else begin
          m_locked = 0;
          if (m_crc_err < 65535) m_crc_err++;
        end
      end
      if (hs && !loaded) m_valid = 0;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_valid", out_valid, m_valid);
      chk("out_data", out_data, m_data);
      chk("out_count", out_count, m_count);
      chk("locked", locked, m_locked);
      chk("crc_err_cnt", crc_err_cnt, m_crc_err[15:0]);
      chk("seq_err_cnt", seq_err_cnt, m_seq_err[15:0]);
      chk("ovf_cnt", ovf_cnt, m_ovf[15:0]);
    end
  end

  // Words accepted by the sink
  int          dut_acc;
  logic [31:0] acc_data;
  logic [7:0]  acc_count;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_acc <= 0; acc_data <= 0; acc_count <= 0;
    end else if (out_valid && out_ready) begin
      dut_acc <= dut_acc + 1; acc_data <= out_data; acc_count <= out_count;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input logic v, input logic b);
    @(negedge clk); #1;
    bit_valid = v; bit_in = b;
    if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [55:0] f, input int nbits, input bit sparse);
    for (int i = 55; i > 55 - nbits; i--) begin
      tick(1'b1, f[i]);
      if (sparse) idle(2);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0; bit_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic        rbits [200];
  logic [31:0] d1, d2, d3;

  initial begin
    logic [7:0]  h;
    logic [55:0] f;
    logic [7:0]  cnt;
    logic        b;

    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;

    // Model pins: hand-computed CRC-8/0x07 values and frame layout
    chk("crc_ref_zero", crc8_ref(40'h0), 8'h00);
    chk("crc_ref_one", crc8_ref(40'h1), 8'h07);
    chk("crc_ref_0100", crc8_ref(40'h100), 8'h15);
    chk("frame_zero", make_frame(8'h00, 32'h0), 56'hA5_00_00000000_00);

    // Reset state
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_counters", {crc_err_cnt, seq_err_cnt, ovf_cnt}, 48'h0);

    // All-zero frame
    send_bits(make_frame(8'h00, 32'h0), 56, 0);
    idle(3);
    chk("t1_words", dut_acc, 1);
    chk("t1_model_words", m_acc, 1);
    chk("t1_data", {acc_count, acc_data}, 40'h0);
    chk("t1_locked", locked, 1'b1);
    chk("t1_counters", {crc_err_cnt, seq_err_cnt, ovf_cnt}, 48'h0);

    // Back-to-back frames, counters 05 06 08
    do_reset();
    d1 = $urandom; d2 = $urandom; d3 = $urandom;
    send_bits(make_frame(8'h05, d1), 56, 0);
    send_bits(make_frame(8'h06, d2), 56, 0);
    send_bits(make_frame(8'h08, d3), 56, 0);
    idle(3);
    chk("t2_words", dut_acc, 3);
    chk("t2_seq_err", seq_err_cnt, 16'd1);
    chk("t2_last", {acc_count, acc_data}, {8'h08, d3});

    // Corrupted payload bit, then a good frame
    do_reset();
    f = make_frame(8'h01, 32'hDEADBEEF) ^ (56'h1 << 20);
    send_bits(f, 56, 0);
    idle(3);
    chk("t3_words", dut_acc, 0);
    chk("t3_crc_err", crc_err_cnt, 16'd1);
    chk("t3_locked", locked, 1'b0);
    send_bits(make_frame(8'h02, 32'h12345678), 56, 0);
    idle(3);
    chk("t3_words2", dut_acc, 1);
    chk("t3_locked2", locked, 1'b1);
    chk("t3_data2", acc_data, 32'h12345678);

    // Random bits with no sync alignment, then a frame; dense and 1-in-3
    h = 8'h00;
    for (int i = 0; i < 192; i++) begin
      b = $urandom_range(0, 1);
      if ({h[6:0], b} == 8'hA5) b = ~b;
      h = {h[6:0], b};
      rbits[i] = b;
    end
    for (int i = 192; i < 200; i++) rbits[i] = 1'b0;
    d1 = $urandom;
    for (int sp = 0; sp < 2; sp++) begin
      do_reset();
      for (int i = 0; i < 200; i++) begin
        tick(1'b1, rbits[i]);
        if (sp == 1) idle(2);
      end
      chk("t4_no_false", dut_acc, 0);
      send_bits(make_frame(8'h33, d1), 56, sp == 1);
      idle(3);
      chk("t4_words", dut_acc, 1);
      chk("t4_data", {acc_count, acc_data}, {8'h33, d1});
      chk("t4_crc_err", crc_err_cnt, 16'd0);
    end

    // Output held with out_ready low across two frames
    do_reset();
    out_ready = 1'b0;
    d1 = $urandom; d2 = $urandom;
    send_bits(make_frame(8'h10, d1), 56, 0);
    send_bits(make_frame(8'h11, d2), 56, 0);
    idle(3);
    chk("t5_valid", out_valid, 1'b1);
    chk("t5_held", {out_count, out_data}, {8'h10, d1});
    chk("t5_ovf", ovf_cnt, 16'd1);
    @(negedge clk); #1 out_ready = 1'b1;
    idle(2);
    chk("t5_released", out_valid, 1'b0);
    chk("t5_words", dut_acc, 1);
    chk("t5_acc", acc_data, d1);

    // Reset mid-payload, then a complete frame
    do_reset();
    send_bits(make_frame(8'h20, 32'hCAFEF00D), 28, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_counters", {crc_err_cnt, seq_err_cnt, ovf_cnt}, 48'h0);
    chk("t6_rst_valid", out_valid, 1'b0);
    @(negedge clk); #1 rst_n = 1'b1;
    send_bits(make_frame(8'h21, 32'h0BADCAFE), 56, 0);
    idle(3);
    chk("t6_words", dut_acc, 1);
    chk("t6_data", {acc_count, acc_data}, {8'h21, 32'h0BADCAFE});
    chk("t6_crc_err", crc_err_cnt, 16'd0);

    // Randomized stream: gaps, corruption, sequence slips, random out_ready
    do_reset();
    rand_ready = 1'b1;
    cnt = 8'($urandom);
    for (int k = 0; k < 40; k++) begin
      cnt = ($urandom_range(0, 9) < 7) ? 8'(cnt + 8'd1) : 8'($urandom);
      f = make_frame(cnt, $urandom);
      if ($urandom_range(0, 9) == 0) f = f ^ (56'h1 << $urandom_range(0, 47));
      for (int i = 55; i >= 0; i--) begin
        tick(1'b1, f[i]);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle($urandom_range(0, 2));
    end
    idle(5);
    rand_ready = 1'b0;
    out_ready = 1'b1;
    idle(3);
    chk("t7_words", dut_acc, m_acc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
